// File: rtl/branch_resolve_pkg.sv
`default_nettype none
// ============================================================================
// Module      : branch_resolve_pkg
// Description : Shared pipeline definitions for the branch resolve stage:
//               FSM state encoding, default datapath width, and the BEQ/BNE
//               opcode-class constants that decode also uses.
// Revision    : 1.0 - initial release
// ============================================================================
package branch_resolve_pkg;

    // Default datapath / PC width
    localparam int unsigned C_DEFAULT_WIDTH = 32;

    // Conditional branch opcode class and funct3 selectors
    localparam logic [6:0] C_OPC_BRANCH = 7'b1100011;
    localparam logic [2:0] C_F3_BEQ     = 3'b000;
    localparam logic [2:0] C_F3_BNE     = 3'b001;

    // Resolve-stage FSM encoding
    typedef enum logic [0:0] {
        BR_IDLE     = 1'b0,
        BR_REDIRECT = 1'b1
    } br_state_e;

    // Resolved direction of a BEQ/BNE given the zero-detector output.
    // With both class bits set the result is meaningless; callers gate it.
    function automatic logic f_branch_taken(input logic beq,
                                            input logic bne,
                                            input logic zero);
        return (beq & zero) | (bne & ~zero);
    endfunction

endpackage : branch_resolve_pkg
`default_nettype wire

// File: rtl/branch_resolve_if.sv
`default_nettype none
// ============================================================================
// Module      : branch_resolve_if
// Description : EX-side inputs and EX/MEM / fetch-redirect outputs of the
//               branch resolve stage. The stage itself uses the slave view.
// Revision    : 1.0 - initial release
// ============================================================================
interface branch_resolve_if
    import branch_resolve_pkg::*;
#(
    parameter int unsigned WIDTH     = C_DEFAULT_WIDTH,
    parameter int unsigned CNT_WIDTH = 16
);
    // EX stage inputs
    logic                 ex_valid;
    logic                 ex_beq;
    logic                 ex_bne;
    logic                 ex_zero;
    logic [WIDTH-1:0]     ex_target;
    logic [WIDTH-1:0]     ex_pc_plus4;
    logic                 ex_pred_taken;
    logic                 mem_stall;

    // Stage outputs
    logic                 mem_valid;
    logic                 mem_taken;
    logic                 redirect;
    logic [WIDTH-1:0]     redirect_pc;
    logic                 flush_ifid;
    logic                 flush_idex;
    logic [CNT_WIDTH-1:0] br_count;
    logic [CNT_WIDTH-1:0] mispred_count;

    modport master (
        output ex_valid, ex_beq, ex_bne, ex_zero, ex_target, ex_pc_plus4,
               ex_pred_taken, mem_stall,
        input  mem_valid, mem_taken, redirect, redirect_pc, flush_ifid,
               flush_idex, br_count, mispred_count
    );

    modport slave (
        input  ex_valid, ex_beq, ex_bne, ex_zero, ex_target, ex_pc_plus4,
               ex_pred_taken, mem_stall,
        output mem_valid, mem_taken, redirect, redirect_pc, flush_ifid,
               flush_idex, br_count, mispred_count
    );

endinterface : branch_resolve_if
`default_nettype wire

// File: rtl/branch_resolve_sat_counter.sv
`default_nettype none
// ============================================================================
// Module      : sat_counter
// Description : Up-counter that sticks at all-ones instead of wrapping.
// Revision    : 1.0 - initial release
// ============================================================================
module sat_counter #(
    parameter int unsigned CNT_WIDTH = 16
) (
    input  wire logic                 clk,
    input  wire logic                 reset_n,
    input  wire logic                 inc,
    output logic      [CNT_WIDTH-1:0] count
);

    logic [CNT_WIDTH-1:0] r_count;

    // Count requested events, holding once the maximum is reached
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_count <= '0;
        end else if (inc && (r_count != {CNT_WIDTH{1'b1}})) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign count = r_count;

endmodule : sat_counter
`default_nettype wire

// File: rtl/branch_resolve.sv
`default_nettype none
// ============================================================================
// Module      : branch_resolve
// Description : EX/MEM stage register that resolves BEQ/BNE against the
//               fetch-time static prediction, issues a one-cycle redirect and
//               pipeline flush on a misprediction, squashes the wrong-path
//               instruction behind it, and keeps saturating branch counters.
// Revision    : 1.0 - initial release
// ============================================================================
module branch_resolve
    import branch_resolve_pkg::*;
#(
    parameter int unsigned WIDTH     = C_DEFAULT_WIDTH,
    parameter int unsigned CNT_WIDTH = 16
) (
    input  wire logic        clk,
    input  wire logic        reset_n,
    branch_resolve_if.slave  bus
);

    br_state_e            r_state;
    br_state_e            w_state_next;

    logic                 r_mem_valid;
    logic                 r_mem_taken;
    logic [WIDTH-1:0]     r_redirect_pc;

    logic                 w_is_br;
    logic                 w_taken;
    logic                 w_mispred;
    logic                 w_advance;
    logic                 w_squash;
    logic                 w_redirect;
    logic                 w_br_inc;
    logic                 w_mis_inc;
    logic [CNT_WIDTH-1:0] w_br_count;
    logic [CNT_WIDTH-1:0] w_mis_count;

    // BEQ and BNE together is an illegal encoding and is treated as a
    // non-branch, so it can neither count nor redirect.
    assign w_is_br   = bus.ex_beq ^ bus.ex_bne;
    assign w_taken   = f_branch_taken(bus.ex_beq, bus.ex_bne, bus.ex_zero);
    assign w_mispred = bus.ex_valid & w_is_br & (w_taken != bus.ex_pred_taken);
    assign w_advance = ~bus.mem_stall;

    // A squashed (wrong-path) instruction is neither counted nor allowed to
    // redirect; mispredicts are only accepted from IDLE.
    assign w_br_inc  = w_advance & bus.ex_valid & w_is_br & ~w_squash;
    assign w_mis_inc = w_advance & (r_state == BR_IDLE) & w_mispred;

    // FSM state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= BR_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next state and Moore redirect/squash outputs
    always_comb begin
        w_state_next = r_state;
        w_redirect   = 1'b0;
        w_squash     = 1'b0;
        case (r_state)
            BR_IDLE: begin
                if (w_mis_inc) begin
                    w_state_next = BR_REDIRECT;
                end
            end
            BR_REDIRECT: begin
                w_redirect = 1'b1;
                w_squash   = 1'b1;
                // Stay put under a stall so fetch keeps seeing the redirect
                if (w_advance) begin
                    w_state_next = BR_IDLE;
                end
            end
            default: begin
                w_state_next = BR_IDLE;
            end
        endcase
    end

    // EX/MEM stage register; holds completely while MEM stalls
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_mem_valid <= 1'b0;
            r_mem_taken <= 1'b0;
        end else if (w_advance) begin
            r_mem_valid <= bus.ex_valid & ~w_squash;
            r_mem_taken <= w_taken & w_is_br;
        end
    end

    // Corrected fetch PC, captured together with the mispredict
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_redirect_pc <= '0;
        end else if (w_mis_inc) begin
            r_redirect_pc <= w_taken ? bus.ex_target : bus.ex_pc_plus4;
        end
    end

    sat_counter #(
        .CNT_WIDTH (CNT_WIDTH)
    ) u_br_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .inc     (w_br_inc),
        .count   (w_br_count)
    );

    sat_counter #(
        .CNT_WIDTH (CNT_WIDTH)
    ) u_mis_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .inc     (w_mis_inc),
        .count   (w_mis_count)
    );

    assign bus.mem_valid     = r_mem_valid;
    assign bus.mem_taken     = r_mem_taken;
    assign bus.redirect      = w_redirect;
    assign bus.redirect_pc   = r_redirect_pc;
    assign bus.flush_ifid    = w_redirect;
    assign bus.flush_idex    = w_redirect;
    assign bus.br_count      = w_br_count;
    assign bus.mispred_count = w_mis_count;

endmodule : branch_resolve
`default_nettype wire

// File: doc/branch_resolve.md
Name: branch_resolve

Overview:
- Pipeline stage directly downstream of the 32-bit zero detector in EX. Forms the EX/MEM boundary.
- Registers the zero flag together with branch-type and target information, and resolves BEQ/BNE against the static prediction made in fetch.
- On a misprediction it issues a one-cycle redirect to fetch, flushes the younger stages, and squashes the wrong-path instruction arriving behind the branch.
- Keeps saturating branch and misprediction counters for performance monitoring.

Parameters:
- WIDTH, 32, datapath/PC width.
- CNT_WIDTH, 16, width of each performance counter.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset_n  in  1  asynchronous active-low reset.
- ex_valid  in  1  EX holds a real instruction.
- ex_beq  in  1  EX instruction is BEQ.
- ex_bne  in  1  EX instruction is BNE.
- ex_zero  in  1  zero-detector output (1 = ALU result == 0).
- ex_target  in  WIDTH  computed branch target.
- ex_pc_plus4  in  WIDTH  fall-through PC.
- ex_pred_taken  in  1  prediction carried from fetch.
- mem_stall  in  1  MEM requests hold; stage must not advance.
- mem_valid  out  1  registered valid into MEM.
- mem_taken  out  1  registered resolved branch outcome.
- redirect  out  1  fetch must load redirect_pc.
- redirect_pc  out  WIDTH  corrected PC.
- flush_ifid  out  1  clear IF/ID register.
- flush_idex  out  1  clear ID/EX register.
- br_count  out  CNT_WIDTH  resolved branches.
- mispred_count  out  CNT_WIDTH  mispredicted branches.

Behaviour:
- Reset (asynchronous, any time, including mid-redirect): every output is 0, the FSM goes to IDLE, and both counters are 0. The first active edge after reset_n rises behaves as IDLE.
- is_br = ex_beq XOR ex_bne. If both are set, the instruction is treated as a non-branch: no count, no redirect, valid passes through.
- taken = (ex_beq & ex_zero) | (ex_bne & ~ex_zero).
- mispred = ex_valid & is_br & (taken != ex_pred_taken).
- Stage register advances only when mem_stall = 0. While mem_stall = 1, all registered outputs hold.
- Captured values: mem_valid <= ex_valid & ~squash; mem_taken <= taken & is_br.
- FSM states:
  - IDLE: if the stage advances and the captured instruction has mispred = 1:
    - go to REDIRECT;
    - redirect_pc <= taken ? ex_target : ex_pc_plus4.
  - REDIRECT: redirect = flush_ifid = flush_idex = 1 as Moore outputs.
    - squash = 1, so the instruction captured this cycle is wrong-path and enters with mem_valid = 0; it is not counted and cannot trigger a redirect.
    - If mem_stall = 1, remain in REDIRECT with outputs held; redirect stays high until the first non-stalled edge.
    - Otherwise return to IDLE.
- Latency: a branch in EX at edge N produces redirect high during cycle N+1, for exactly one cycle if there is no stall.
- Back-to-back branches: a branch arriving during REDIRECT is squashed and ignored, because it is on the wrong path.
- Counters:
  - br_count increments on each captured, unsquashed, valid is_br.
  - mispred_count increments on each IDLE→REDIRECT transition.
  - Both saturate at all-ones; there is no wrap.
  - Neither counter changes while mem_stall = 1.

Decomposition:
- Shared package (pipeline package):
  - FSM state encoding: BR_IDLE = 1'b0, BR_REDIRECT = 1'b1.
  - Default WIDTH = 32.
  - Opcode-class constants for BEQ/BNE so decode and this block share one definition.
- One sub-module: sat_counter (parameter CNT_WIDTH; inputs clk, reset_n, inc; output count). Instantiated twice.

Test Plan:
- Reset then idle: assert reset_n=0 mid-cycle, then release → all outputs 0 immediately and stay 0 with ex_valid=0.
- BEQ, zero=1, pred=0, target=0x0000_0040, pc+4=0x0000_0014 → next cycle redirect=1, redirect_pc=0x40, both flushes 1 for one cycle; mispred_count=1, br_count=1.
- BNE, zero=1, pred=0 → correctly predicted not-taken: no redirect, mem_taken=0, br_count increments, mispred_count unchanged.
- Mispredicted branch, then BEQ (also mispredicting) arrives during REDIRECT → second branch has mem_valid=0, no second redirect; counts 1/1.
- Mispredict with mem_stall=1 for 3 cycles at the redirect edge → redirect held high for 4 cycles, redirect_pc stable; the instruction behind is squashed once the stall releases.
- Drive 2^CNT_WIDTH+5 mispredicts (CNT_WIDTH=4 build) → both counters stick at 0xF. Assert reset_n=0 while in REDIRECT → redirect drops asynchronously and counters clear.
